// File: rtl/blast_pkg.sv
// Shared definitions for the Blastn hit-drain path: FSM encoding, hit record
// layout and the summary FIFO read latency.
package blast_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_HOLD  = 2'd3;

  // Cycles between a read_HSP strobe and valid data on the unit outputs.
  localparam int unsigned FIFO_RD_LATENCY = 1;

  localparam int HIT_FIELD_W = 8;
  localparam int HIT_IDX_W   = 2;

  typedef struct packed {
    logic [HIT_FIELD_W-1:0] q;
    logic [HIT_FIELD_W-1:0] s;
    logic [HIT_FIELD_W-1:0] len;
    logic [HIT_IDX_W-1:0]   idx;
  } hit_rec_t;

endpackage

// File: rtl/hsp_drain_arbiter_rr_select.sv
// Combinational round-robin picker: grants the first requester after ptr,
// wrapping, so the previously served index has the lowest priority.
module rr_select #(
  parameter int N     = 4,
  parameter int IDX_W = 2
) (
  input  logic [N-1:0]     request,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] grant,
  output logic             grant_valid
);

  int          cand;
  logic [N-1:0] shifted;

  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    cand        = 0;
    shifted     = '0;
    for (int k = 1; k <= N; k++) begin
      cand    = (int'(ptr) + k) % N;
      shifted = request >> cand;
      if (!grant_valid && shifted[0]) begin
        grant       = IDX_W'(cand);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/hsp_drain_arbiter.sv
// Round-robin drain of the per-unit HSP summary FIFOs into a single tagged
// hit stream, with drop/hit statistics, overflow and drain-complete flags.
module hsp_drain_arbiter
  import blast_pkg::*;
#(
  parameter int NUMBER_ARRAY   = 4,
  parameter int LENGTH_COUNTER = 8,
  parameter int IDX_W          = 2,
  parameter int CNT_W          = 16
) (
  input  logic                                   array_clk,
  input  logic                                   reset,
  input  logic                                   start,
  input  logic                                   sweep_done,
  input  logic [NUMBER_ARRAY-1:0]                fifo_empty,
  input  logic [NUMBER_ARRAY-1:0]                fifo_full,
  input  logic [NUMBER_ARRAY*LENGTH_COUNTER-1:0] hit_q_in,
  input  logic [NUMBER_ARRAY*LENGTH_COUNTER-1:0] hit_s_in,
  input  logic [NUMBER_ARRAY*LENGTH_COUNTER-1:0] hit_len_in,
  output logic [NUMBER_ARRAY-1:0]                read_HSP,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [LENGTH_COUNTER-1:0]              out_q,
  output logic [LENGTH_COUNTER-1:0]              out_s,
  output logic [LENGTH_COUNTER-1:0]              out_len,
  output logic [IDX_W-1:0]                       out_idx,
  output logic [CNT_W-1:0]                       hit_count,
  output logic [CNT_W-1:0]                       drop_count,
  output logic                                   overflow,
  output logic                                   drain_done
);

  logic [1:0]                state;
  logic [IDX_W-1:0]          ptr;
  logic [IDX_W-1:0]          sel;
  logic [1:0]                lat_cnt;
  logic [NUMBER_ARRAY-1:0]   request;
  logic [IDX_W-1:0]          grant;
  logic                      grant_valid;
  logic [LENGTH_COUNTER-1:0] sel_q, sel_s, sel_len;
  logic                      hit_inc, drop_inc, drain_cond, data_ready;
  logic [CNT_W-1:0]          hit_base, drop_base;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign request = ~fifo_empty;

  rr_select #(
    .N     (NUMBER_ARRAY),
    .IDX_W (IDX_W)
  ) u_rr_select (
    .request     (request),
    .ptr         (ptr),
    .grant       (grant),
    .grant_valid (grant_valid)
  );

  always_comb begin
    sel_q   = LENGTH_COUNTER'(hit_q_in   >> (int'(sel) * LENGTH_COUNTER));
    sel_s   = LENGTH_COUNTER'(hit_s_in   >> (int'(sel) * LENGTH_COUNTER));
    sel_len = LENGTH_COUNTER'(hit_len_in >> (int'(sel) * LENGTH_COUNTER));
  end

  assign data_ready = (state == ST_WAIT) && (lat_cnt == 2'd0);
  assign hit_inc    = (state == ST_HOLD) && out_valid && out_ready;
  assign drop_inc   = data_ready && (sel_len == '0);
  assign drain_cond = sweep_done && (&fifo_empty) && (state == ST_IDLE) && !out_valid;

  // start clears first, so an increment landing in the same cycle yields 1.
  assign hit_base  = start ? '0 : hit_count;
  assign drop_base = start ? '0 : drop_count;

  always_ff @(posedge array_clk or negedge reset) begin
    if (!reset) begin
      state     <= ST_IDLE;
      ptr       <= IDX_W'(NUMBER_ARRAY - 1);
      sel       <= '0;
      lat_cnt   <= '0;
      read_HSP  <= '0;
      out_valid <= 1'b0;
      out_q     <= '0;
      out_s     <= '0;
      out_len   <= '0;
      out_idx   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_valid) begin
            sel      <= grant;
            read_HSP <= {{(NUMBER_ARRAY-1){1'b0}}, 1'b1} << grant;
            state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          read_HSP <= '0;
          lat_cnt  <= 2'(FIFO_RD_LATENCY - 1);
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (lat_cnt != 2'd0) begin
            lat_cnt <= lat_cnt - 1'b1;
          end else begin
            ptr <= sel;
            if (sel_len == '0) begin
              state <= ST_IDLE;
            end else begin
              out_q     <= sel_q;
              out_s     <= sel_s;
              out_len   <= sel_len;
              out_idx   <= sel;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          read_HSP  <= '0;
          out_valid <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  // Statistics and sticky flags; start clears but never touches the FSM.
  always_ff @(posedge array_clk or negedge reset) begin
    if (!reset) begin
      hit_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
      drain_done <= 1'b0;
    end else begin
      hit_count  <= hit_inc  ? sat_inc(hit_base)  : hit_base;
      drop_count <= drop_inc ? sat_inc(drop_base) : drop_base;
      overflow   <= (overflow && !start) || (|fifo_full);
      drain_done <= (drain_done && !start) || drain_cond;
    end
  end

endmodule

// File: tb/tb_hsp_drain_arbiter.sv
// Scoreboard bench for hsp_drain_arbiter: a FIFO model feeds the DUT, expected
// hits are queued at stimulus time and popped by a monitor on each handshake.
module tb_hsp_drain_arbiter;
  import blast_pkg::*;

  localparam int NA = 4;
  localparam int LC = 8;
  localparam int IW = 2;
  localparam int CW = 16;

  logic              array_clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0;
  logic              sweep_done = 1'b0;
  logic              out_ready = 1'b0;
  logic [NA-1:0]     fifo_empty = '1;
  logic [NA-1:0]     fifo_full = '0;
  logic [NA*LC-1:0]  hit_q_in = '0;
  logic [NA*LC-1:0]  hit_s_in = '0;
  logic [NA*LC-1:0]  hit_len_in = '0;
  logic [NA-1:0]     read_HSP;
  logic              out_valid;
  logic [LC-1:0]     out_q, out_s, out_len;
  logic [IW-1:0]     out_idx;
  logic [CW-1:0]     hit_count, drop_count;
  logic              overflow, drain_done;

  int       checks = 0;
  int       errors = 0;
  hit_rec_t expq[$];
  hit_rec_t mq[NA][$];
  hit_rec_t mdl_h;
  hit_rec_t mon_e;

  hsp_drain_arbiter #(
    .NUMBER_ARRAY(NA), .LENGTH_COUNTER(LC), .IDX_W(IW), .CNT_W(CW)
  ) dut (
    .array_clk(array_clk), .reset(reset), .start(start), .sweep_done(sweep_done),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .hit_q_in(hit_q_in), .hit_s_in(hit_s_in), .hit_len_in(hit_len_in),
    .read_HSP(read_HSP), .out_valid(out_valid), .out_ready(out_ready),
    .out_q(out_q), .out_s(out_s), .out_len(out_len), .out_idx(out_idx),
    .hit_count(hit_count), .drop_count(drop_count),
    .overflow(overflow), .drain_done(drain_done)
  );

  always #5 array_clk = ~array_clk;

  // Summary FIFO model: a strobe seen in the ISSUE cycle pops the head onto the unit outputs.
  always @(negedge array_clk) begin
    if (read_HSP != '0) begin
      checks++;
      if (!$onehot(read_HSP)) begin
        errors++;
        $display("[TB] FAIL read_onehot: got %b, required one-hot", read_HSP);
      end
    end
    for (int i = 0; i < NA; i++) begin
      if (read_HSP[i]) begin
        checks++;
        if (mq[i].size() == 0) begin
          errors++;
          $display("[TB] FAIL read_empty: unit %0d strobed while empty, required no strobe", i);
        end else begin
          mdl_h = mq[i].pop_front();
          hit_q_in[i*LC +: LC]   = mdl_h.q;
          hit_s_in[i*LC +: LC]   = mdl_h.s;
          hit_len_in[i*LC +: LC] = mdl_h.len;
        end
      end
    end
    for (int i = 0; i < NA; i++) fifo_empty[i] = (mq[i].size() == 0);
  end

  always @(negedge array_clk) begin
    if (reset && out_valid && out_ready) begin
      checks++;
      if (expq.size() == 0) begin
        errors++;
        $display("[TB] FAIL hit_unexpected: got q=%h s=%h len=%h idx=%0d, required no hit",
                 out_q, out_s, out_len, out_idx);
      end else begin
        mon_e = expq.pop_front();
        if ({out_q, out_s, out_len, out_idx} !== {mon_e.q, mon_e.s, mon_e.len, mon_e.idx}) begin
          errors++;
          $display("[TB] FAIL hit_data: got q=%h s=%h len=%h idx=%0d, required q=%h s=%h len=%h idx=%0d",
                   out_q, out_s, out_len, out_idx, mon_e.q, mon_e.s, mon_e.len, mon_e.idx);
        end
      end
    end
  end

  task automatic tick();
    @(posedge array_clk);
    #1;
  endtask

  task automatic applyStimulus(input int unit, input logic [7:0] q, input logic [7:0] s,
                               input logic [7:0] len);
    hit_rec_t h;
    h.q = q; h.s = s; h.len = len; h.idx = IW'(unit);
    mq[unit].push_back(h);
  endtask

  task automatic expectHit(input logic [7:0] q, input logic [7:0] s, input logic [7:0] len,
                           input int idx);
    hit_rec_t h;
    h.q = q; h.s = s; h.len = len; h.idx = IW'(idx);
    expq.push_back(h);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, actual, required);
    end
  endtask

  task automatic pulseStart();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b0;
    #3;
    repeat (2) @(posedge array_clk);
    #1 reset = 1'b1;
  endtask

  task automatic waitIdle(input string name, input int budget);
    int stable = 0;
    int n = 0;
    while (stable < 3 && n < budget) begin
      @(negedge array_clk);
      n++;
      if (expq.size() == 0 && fifo_empty == '1 && !out_valid && read_HSP == '0) stable++;
      else stable = 0;
    end
    checks++;
    if (stable < 3) begin
      errors++;
      $display("[TB] FAIL %s: timeout, %0d hits still expected, required 0", name, expq.size());
    end
  endtask

  task automatic waitOutValid(input string name, input int budget);
    int n = 0;
    do begin
      @(negedge array_clk);
      n++;
    end while (!out_valid && n < budget);
    checks++;
    if (!out_valid) begin
      errors++;
      $display("[TB] FAIL %s: out_valid=0 after %0d cycles, required 1", name, budget);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [NA-1:0] pulse;
    logic          stable_ok;
    int            n;

    doReset();
    @(negedge array_clk);
    checkOutput("rst_read", 32'(read_HSP), 0);
    checkOutput("rst_valid", 32'(out_valid), 0);
    checkOutput("rst_hits", 32'(hit_count), 0);
    checkOutput("rst_flags", {30'd0, overflow, drain_done}, 0);

    // Asynchronous reset while a hit is held
    tick();
    applyStimulus(2, 8'h05, 8'h09, 8'h03);
    waitOutValid("midhold_valid", 20);
    #2 reset = 1'b0;
    #1;
    checkOutput("midhold_read", 32'(read_HSP), 0);
    checkOutput("midhold_valid_async", 32'(out_valid), 0);
    checkOutput("midhold_q", 32'(out_q), 0);
    repeat (2) @(posedge array_clk);
    #1 reset = 1'b1;
    @(negedge array_clk);
    checkOutput("midhold_ptr", 32'(dut.ptr), NA - 1);
    checkOutput("midhold_hits", 32'(hit_count), 0);

    // Single hit from unit 2
    tick();
    out_ready = 1'b1;
    applyStimulus(2, 8'h21, 8'h07, 8'h04);
    expectHit(8'h21, 8'h07, 8'h04, 2);
    n = 0;
    do begin
      @(negedge array_clk);
      n++;
    end while (read_HSP == '0 && n < 10);
    pulse = read_HSP;
    checkOutput("single_read", 32'(pulse), 32'b0100);
    @(negedge array_clk);
    checkOutput("single_read_width", 32'(read_HSP), 0);
    waitIdle("single_drain", 40);
    checkOutput("single_hits", 32'(hit_count), 1);

    // Fairness from a fresh pointer: two hits in every unit
    doReset();
    out_ready = 1'b1;
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NA; i++)
        applyStimulus(i, 8'(16 * i + k), 8'(8'hA0 + 4 * i + k), 8'(1 + i + 2 * k));
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < NA; i++)
        expectHit(8'(16 * i + k), 8'(8'hA0 + 4 * i + k), 8'(1 + i + 2 * k), i);
    waitIdle("fair_drain", 100);
    checkOutput("fair_hits", 32'(hit_count), 8);

    // Zero-length entry is dropped, the following one delivered
    pulseStart();
    applyStimulus(1, 8'h31, 8'h32, 8'h00);
    applyStimulus(1, 8'h41, 8'h42, 8'h06);
    expectHit(8'h41, 8'h42, 8'h06, 1);
    waitIdle("drop_drain", 40);
    checkOutput("drop_drops", 32'(drop_count), 1);
    checkOutput("drop_hits", 32'(hit_count), 1);

    // Backpressure; release coincides with start so the count restarts at 1
    tick();
    out_ready = 1'b0;
    applyStimulus(3, 8'h55, 8'h66, 8'h07);
    applyStimulus(0, 8'h12, 8'h34, 8'h09);
    expectHit(8'h55, 8'h66, 8'h07, 3);
    expectHit(8'h12, 8'h34, 8'h09, 0);
    waitOutValid("bp_valid", 20);
    stable_ok = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge array_clk);
      if (!out_valid || read_HSP != '0 ||
          {out_q, out_s, out_len, out_idx} != {8'h55, 8'h66, 8'h07, 2'd3})
        stable_ok = 1'b0;
    end
    checkOutput("bp_stable", 32'(stable_ok), 1);
    tick();
    out_ready = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("bp_single_hs", 32'(out_valid), 0);
    checkOutput("bp_start_inc", 32'(hit_count), 1);
    waitIdle("bp_drain", 40);
    checkOutput("bp_hits", 32'(hit_count), 2);
    checkOutput("bp_drops", 32'(drop_count), 0);

    // Overflow and drain completion
    pulseStart();
    fifo_full[3] = 1'b1;
    tick();
    fifo_full = '0;
    sweep_done = 1'b1;
    repeat (3) tick();
    checkOutput("ovf_set", 32'(overflow), 1);
    checkOutput("drain_set", 32'(drain_done), 1);
    applyStimulus(0, 8'h77, 8'h78, 8'h02);
    expectHit(8'h77, 8'h78, 8'h02, 0);
    waitOutValid("drain_refill", 20);
    checkOutput("drain_held", 32'(drain_done), 1);
    waitIdle("drain_drain", 40);
    checkOutput("drain_hits", 32'(hit_count), 1);
    tick();
    sweep_done = 1'b0;
    pulseStart();
    checkOutput("clr_ovf", 32'(overflow), 0);
    checkOutput("clr_drain", 32'(drain_done), 0);
    checkOutput("clr_counts", {hit_count, drop_count}, 0);
    tick();
    start = 1'b1;
    fifo_full[1] = 1'b1;
    tick();
    start = 1'b0;
    fifo_full = '0;
    checkOutput("ovf_start_coincide", 32'(overflow), 1);
    pulseStart();
    checkOutput("ovf_cleared", 32'(overflow), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
